// File: rtl/perf_counter_bank_if.sv
// Signal bundle for perf_counter_bank: event/control inputs, read port and overflow flags.
// Defining PERF_SNAPSHOT_EN adds the snap and rd_shadow controls.
interface perf_counter_bank_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic [NCH-1:0]   inc;
    logic [NCH-1:0]   clr;
    logic             freeze;
    logic             load;
    logic [SELW-1:0]  load_sel;
    logic [WIDTH-1:0] load_val;
    logic [SELW-1:0]  rd_sel;
    logic [WIDTH-1:0] rd_data;
    logic [NCH-1:0]   ovf;
    logic [NCH-1:0]   ovf_clr;
`ifdef PERF_SNAPSHOT_EN
    logic             snap;
    logic             rd_shadow;
`endif

    modport master (
`ifdef PERF_SNAPSHOT_EN
        output snap, rd_shadow,
`endif
        output inc, clr, freeze, load, load_sel, load_val, rd_sel, ovf_clr,
        input  rd_data, ovf
    );

    modport slave (
`ifdef PERF_SNAPSHOT_EN
        input  snap, rd_shadow,
`endif
        input  inc, clr, freeze, load, load_sel, load_val, rd_sel, ovf_clr,
        output rd_data, ovf
    );
endinterface

// File: rtl/perf_counter_bank.sv
// Bank of NCH event counters with clear/load/increment priority, sticky overflow and a registered read mux.
// Optional PERF_SNAPSHOT_EN adds shadow registers captured by snap and read via rd_shadow.
module perf_counter_bank #(
    parameter int WIDTH    = 32,
    parameter int NCH      = 4,
    parameter int SELW     = 2,
    parameter int SATURATE = 0
) (
    input logic                clk,
    input logic                rst_n,
    perf_counter_bank_if.slave bus
);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] count_q [NCH];
    logic [WIDTH-1:0] count_d [NCH];
    logic [NCH-1:0]   ovf_q;
    logic [NCH-1:0]   ovf_d;
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // Priority per channel: clr, then a matching load, then an unfrozen increment.
    always_comb begin
        ovf_d = ovf_q & ~bus.ovf_clr;
        for (int ch = 0; ch < NCH; ch++) begin
            count_d[ch] = count_q[ch];
            if (bus.clr[ch]) begin
                count_d[ch] = '0;
            end else if (bus.load && (bus.load_sel == SELW'(ch))) begin
                count_d[ch] = bus.load_val;
            end else if (bus.inc[ch] && !bus.freeze) begin
                if (count_q[ch] == ALL_ONES) begin
                    ovf_d[ch]   = 1'b1;
                    count_d[ch] = (SATURATE != 0) ? ALL_ONES : '0;
                end else begin
                    count_d[ch] = count_q[ch] + WIDTH'(1);
                end
            end
        end
    end

`ifdef PERF_SNAPSHOT_EN
    logic [WIDTH-1:0] shadow_q [NCH];
    logic [WIDTH-1:0] shadow_d [NCH];

    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            shadow_d[ch] = bus.snap ? count_q[ch] : shadow_q[ch];
        end
    end
`endif

    // Read mux sees pre-update values; selects beyond NCH fall through to zero.
    always_comb begin
        rd_data_d = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (bus.rd_sel == SELW'(ch)) begin
`ifdef PERF_SNAPSHOT_EN
                rd_data_d = bus.rd_shadow ? shadow_q[ch] : count_q[ch];
`else
                rd_data_d = count_q[ch];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                count_q[ch] <= '0;
`ifdef PERF_SNAPSHOT_EN
                shadow_q[ch] <= '0;
`endif
            end
            ovf_q     <= '0;
            rd_data_q <= '0;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                count_q[ch] <= count_d[ch];
`ifdef PERF_SNAPSHOT_EN
                shadow_q[ch] <= shadow_d[ch];
`endif
            end
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Random + directed bench for perf_counter_bank: a wrapping and a saturating instance share stimulus
// and are checked every cycle against a behavioural model of the counter bank.
module tb_perf_counter_bank;
    localparam int W    = 8;
    localparam int N    = 3;
    localparam int S    = 2;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    perf_counter_bank_if #(.WIDTH(W), .NCH(N), .SELW(S)) ifa ();
    perf_counter_bank_if #(.WIDTH(W), .NCH(N), .SELW(S)) ifb ();

    perf_counter_bank #(.WIDTH(W), .NCH(N), .SELW(S), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    perf_counter_bank #(.WIDTH(W), .NCH(N), .SELW(S), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    assign ifb.inc      = ifa.inc;
    assign ifb.clr      = ifa.clr;
    assign ifb.freeze   = ifa.freeze;
    assign ifb.load     = ifa.load;
    assign ifb.load_sel = ifa.load_sel;
    assign ifb.load_val = ifa.load_val;
    assign ifb.rd_sel   = ifa.rd_sel;
    assign ifb.ovf_clr  = ifa.ovf_clr;
`ifdef PERF_SNAPSHOT_EN
    assign ifb.snap      = ifa.snap;
    assign ifb.rd_shadow = ifa.rd_shadow;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state, index 0 = wrapping instance, 1 = saturating instance.
    int unsigned m_cnt [2][N];
    int unsigned m_shd [2][N];
    bit [N-1:0]  m_ovf [2];
    int unsigned m_rd  [2];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_zero();
        for (int d = 0; d < 2; d++) begin
            m_ovf[d] = '0;
            m_rd[d]  = 0;
            for (int c = 0; c < N; c++) begin
                m_cnt[d][c] = 0;
                m_shd[d][c] = 0;
            end
        end
    endtask

    // Advance one clock: predict from current inputs, wait the edge, commit (unless in reset).
    task automatic cycle();
        int unsigned n_cnt [2][N];
        int unsigned n_shd [2][N];
        bit [N-1:0]  n_ovf [2];
        int unsigned n_rd  [2];
        bit snap_i = 1'b0;
        bit rds_i  = 1'b0;
        int sel = int'(ifa.rd_sel);
`ifdef PERF_SNAPSHOT_EN
        snap_i = ifa.snap;
        rds_i  = ifa.rd_shadow;
`endif
        for (int d = 0; d < 2; d++) begin
            n_rd[d]  = 0;
            if (sel < N) n_rd[d] = rds_i ? m_shd[d][sel] : m_cnt[d][sel];
            n_ovf[d] = m_ovf[d] & ~ifa.ovf_clr;
            for (int c = 0; c < N; c++) begin
                n_shd[d][c] = snap_i ? m_cnt[d][c] : m_shd[d][c];
                if (ifa.clr[c]) n_cnt[d][c] = 0;
                else if (ifa.load && int'(ifa.load_sel) == c) n_cnt[d][c] = int'(ifa.load_val);
                else if (ifa.inc[c] && !ifa.freeze) begin
                    if (m_cnt[d][c] == MAXV) begin
                        n_ovf[d][c] = 1'b1;
                        n_cnt[d][c] = (d == 1) ? MAXV : 0;
                    end else begin
                        n_cnt[d][c] = m_cnt[d][c] + 1;
                    end
                end else n_cnt[d][c] = m_cnt[d][c];
            end
        end
        @(posedge clk);
        if (rst_n) begin
            m_cnt = n_cnt;
            m_shd = n_shd;
            m_ovf = n_ovf;
            m_rd  = n_rd;
        end else begin
            model_zero();
        end
        #1;
    endtask

    task automatic idle_inputs();
        ifa.inc = '0; ifa.clr = '0; ifa.freeze = 1'b0; ifa.load = 1'b0;
        ifa.load_sel = '0; ifa.load_val = '0; ifa.ovf_clr = '0;
`ifdef PERF_SNAPSHOT_EN
        ifa.snap = 1'b0; ifa.rd_shadow = 1'b0;
`endif
    endtask

    task automatic do_load(input int c, input int unsigned v);
        ifa.load = 1'b1; ifa.load_sel = S'(c); ifa.load_val = W'(v);
        cycle();
        ifa.load = 1'b0;
    endtask

    // Asynchronous reset asserted away from any edge; outputs must clear before the next edge.
    task automatic mid_reset(input int hold);
        #2 rst_n = 1'b0;
        model_zero();
        #1;
        check("reset_rd_wrap", ifa.rd_data, 0);
        check("reset_rd_sat", ifb.rd_data, 0);
        check("reset_ovf_wrap", ifa.ovf, 0);
        check("reset_ovf_sat", ifb.ovf, 0);
        for (int i = 0; i < hold; i++) cycle();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rd_data_wrap", ifa.rd_data, m_rd[0]);
            check("rd_data_sat", ifb.rd_data, m_rd[1]);
            check("ovf_wrap", ifa.ovf, m_ovf[0]);
            check("ovf_sat", ifb.ovf, m_ovf[1]);
        end
    end

    initial begin
        idle_inputs();
        ifa.rd_sel = '0;
        model_zero();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // T1: count ch0 up to 37, then reset mid-count and confirm counting restarts.
        do_load(0, 35);
        ifa.inc = 3'b001;
        cycle(); cycle();
        ifa.inc = '0;
        cycle();
        check("t1_pre_reset", ifa.rd_data, 37);
        ifa.inc = 3'b001;
        mid_reset(2);
        cycle();
        ifa.inc = '0;
        cycle();
        check("t1_resume", ifa.rd_data, 1);

        // T2: 10 increments on ch1, then 10 with freeze on for 3 of them.
        ifa.rd_sel = 2'd1;
        ifa.clr = 3'b010; cycle(); ifa.clr = '0;
        ifa.inc = 3'b010;
        for (int i = 0; i < 10; i++) cycle();
        ifa.inc = '0; cycle();
        check("t2_count10", ifa.rd_data, 10);
        ifa.clr = 3'b010; cycle(); ifa.clr = '0;
        ifa.inc = 3'b010;
        for (int i = 0; i < 10; i++) begin
            ifa.freeze = (i >= 2 && i < 5);
            cycle();
        end
        ifa.inc = '0; ifa.freeze = 1'b0; cycle();
        check("t2_freeze7", ifa.rd_data, 7);

        // T3: clr beats load beats inc; then load beats inc.
        ifa.rd_sel = 2'd2;
        do_load(2, 9);
        ifa.clr = 3'b100; ifa.inc = 3'b100;
        do_load(2, 8'h33);
        ifa.clr = '0;
        do_load(2, 8'h55);
        check("t3_clr_wins", ifa.rd_data, 0);
        ifa.inc = '0; cycle();
        check("t3_load_wins", ifa.rd_data, 8'h55);

        // T4: overflow at all-ones, wrap vs saturate, and set beating clear.
        ifa.rd_sel = 2'd0;
        ifa.ovf_clr = '1; cycle(); ifa.ovf_clr = '0;
        do_load(0, MAXV);
        ifa.inc = 3'b001; cycle();
        ifa.inc = '0; cycle();
        check("t4_wrap_val", ifa.rd_data, 0);
        check("t4_sat_val", ifb.rd_data, MAXV);
        check("t4_wrap_ovf", ifa.ovf, 3'b001);
        check("t4_sat_ovf", ifb.ovf, 3'b001);
        do_load(0, MAXV);
        ifa.inc = 3'b001; ifa.ovf_clr = 3'b001; cycle();
        ifa.inc = '0; ifa.ovf_clr = '0; cycle();
        check("t4_set_beats_clr", ifa.ovf, 3'b001);
        ifa.ovf_clr = 3'b001; cycle(); ifa.ovf_clr = '0; cycle();
        check("t4_ovf_cleared", ifa.ovf, 3'b000);

        // T5: out-of-range load is ignored and out-of-range read returns 0.
        do_load(1, 8'h12);
        do_load(3, 8'hAA);
        ifa.rd_sel = 2'd3; cycle();
        check("t5_rd_oob", ifa.rd_data, 0);
        ifa.rd_sel = 2'd1; cycle();
        check("t5_ch1_kept", ifa.rd_data, 8'h12);

`ifdef PERF_SNAPSHOT_EN
        // T6: shadow holds the snapshot while the live counter moves on.
        ifa.rd_sel = 2'd0;
        do_load(0, 100);
        ifa.snap = 1'b1; cycle(); ifa.snap = 1'b0;
        ifa.inc = 3'b001;
        for (int i = 0; i < 5; i++) cycle();
        ifa.inc = '0;
        ifa.rd_shadow = 1'b1; cycle();
        check("t6_shadow", ifa.rd_data, 100);
        ifa.rd_shadow = 1'b0; cycle();
        check("t6_live", ifa.rd_data, 105);
`endif

        // Random phase with one asynchronous reset in the middle.
        for (int i = 0; i < 2000; i++) begin
            ifa.inc     = N'($urandom);
            ifa.clr     = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            ifa.freeze  = ($urandom_range(0, 7) == 0);
            ifa.load    = ($urandom_range(0, 3) == 0);
            ifa.load_sel = S'($urandom_range(0, 3));
            ifa.load_val = ($urandom_range(0, 1) == 0) ? W'(MAXV - $urandom_range(0, 3)) : W'($urandom);
            ifa.ovf_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            ifa.rd_sel  = S'($urandom_range(0, 3));
`ifdef PERF_SNAPSHOT_EN
            ifa.snap      = ($urandom_range(0, 7) == 0);
            ifa.rd_shadow = ($urandom_range(0, 3) == 0);
`endif
            if (i == 1000) mid_reset(3);
            else cycle();
        end

        idle_inputs();
        cycle();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
